mc_control_fsm: RTL and testbench

Multicycle control sequencer for the RV32I datapath: alu, register_file, DataMemory, imm, pc, Branch and the four operand/result muxes. It latches each instruction into an internal instruction register and steps it through FETCH/DECODE/EXEC/MEM/WB. Every register, memory and PC write is issued in exactly one defined cycle. Data-memory accesses use a ready handshake with a timeout, so a slow or missing memory cannot corrupt state.

---
 rtl/rv_ctrl_pkg.sv | 58 +++++
 rtl/mc_decode.sv | 26 ++
 rtl/mc_control_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multicycle control sequencer:
// opcodes, FSM states, instruction classes and datapath mux selects.
package rv_ctrl_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_HALT   = 7'b0000000;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
      C_LUI, C_AUIPC, C_HALT, C_NOP
   } iclass_e;

   localparam logic       MUX2_PC    = 1'b0;
   localparam logic       MUX2_RS1   = 1'b1;
   localparam logic       MUX3_RS2   = 1'b0;
   localparam logic       MUX3_IMM   = 1'b1;
   localparam logic [1:0] MUX4_DM    = 2'b00;
   localparam logic [1:0] MUX4_ALU   = 2'b01;
   localparam logic [1:0] MUX4_PC4   = 2'b10;
   localparam logic       PC_SRC_SUM = 1'b0;
   localparam logic       PC_SRC_ALU = 1'b1;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [4:0] BR_NONE = 5'b11111;
   localparam logic [4:0] BR_JUMP = 5'b01111;

   typedef struct packed {
      logic       rs1_zero;
      logic       mux2;
      logic       mux3;
      logic [2:0] func3;
      logic       subsra;
      logic [4:0] br_opcode;
   } alu_ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode classifier: maps ir[6:0] to an instruction class for the sequencer.
module mc_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output iclass_e    iclass_o
);

   always_comb begin
      iclass_o = C_NOP;
      case (opcode_i)
         OP_R:      iclass_o = C_R;
         OP_IMM:    iclass_o = C_IMM;
         OP_LOAD:   iclass_o = C_LOAD;
         OP_STORE:  iclass_o = C_STORE;
         OP_BRANCH: iclass_o = C_BRANCH;
         OP_JAL:    iclass_o = C_JAL;
         OP_JALR:   iclass_o = C_JALR;
         OP_LUI:    iclass_o = C_LUI;
         OP_AUIPC:  iclass_o = C_AUIPC;
         OP_HALT:   iclass_o = C_HALT;
         default:   iclass_o = C_NOP;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// data-memory ready handshake guarded by a timeout that parks in FAULT.
module mc_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] im_instr,
   input  logic            branch_next,
   input  logic            dm_ready,
   output logic [XLEN-1:0] ir,
   output logic            rs1_zero,
   output logic            pc_we,
   output logic            pc_src,
   output logic            rf_we,
   output logic            dm_req,
   output logic            dm_we,
   output logic [2:0]      alu_func3,
   output logic            alu_subsra,
   output logic            mux2_sel,
   output logic            mux3_sel,
   output logic [1:0]      mux4_sel,
   output logic [4:0]      br_opcode,
   output logic [2:0]      state,
   output logic            halted,
   output logic            fault,
   output logic [XLEN-1:0] instret
);

   localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   ir_q, ir_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   iclass_e           iclass;
   alu_ctrl_t         actl;

   mc_decode u_decode (
      .opcode_i (ir_q[6:0]),
      .iclass_o (iclass)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         instret_q <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
         tmo_q     <= tmo_d;
      end
   end

   assign ir_d      = (state_q == S_FETCH) ? im_instr : ir_q;
   assign instret_d = pc_we ? instret_q + XLEN'(1) : instret_q;

   // ALU/operand controls per class; held through EXEC, MEM and WB.
   always_comb begin
      actl           = '0;
      actl.br_opcode = BR_NONE;
      case (iclass)
         C_R: begin
            actl.mux2   = MUX2_RS1;
            actl.mux3   = MUX3_RS2;
            actl.func3  = ir_q[14:12];
            actl.subsra = ir_q[30];
         end
         C_IMM: begin
            actl.mux2   = MUX2_RS1;
            actl.mux3   = MUX3_IMM;
            actl.func3  = ir_q[14:12];
            actl.subsra = (ir_q[14:12] == F3_SR) ? ir_q[30] : 1'b0;
         end
         C_LOAD, C_STORE: begin
            actl.mux2 = MUX2_RS1;
            actl.mux3 = MUX3_IMM;
         end
         C_BRANCH: begin
            actl.mux2      = MUX2_PC;
            actl.mux3      = MUX3_IMM;
            actl.br_opcode = {2'b00, ir_q[14:12]};
         end
         C_JAL: begin
            actl.mux2      = MUX2_PC;
            actl.mux3      = MUX3_IMM;
            actl.br_opcode = BR_JUMP;
         end
         C_JALR: begin
            actl.mux2      = MUX2_RS1;
            actl.mux3      = MUX3_IMM;
            actl.br_opcode = BR_JUMP;
         end
         C_LUI: begin
            actl.rs1_zero = 1'b1;
            actl.mux2     = MUX2_RS1;
            actl.mux3     = MUX3_IMM;
         end
         C_AUIPC: begin
            actl.mux2 = MUX2_PC;
            actl.mux3 = MUX3_IMM;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_SUM;
      rf_we      = 1'b0;
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      rs1_zero   = 1'b0;
      mux2_sel   = MUX2_PC;
      mux3_sel   = MUX3_RS2;
      mux4_sel   = MUX4_DM;
      alu_func3  = F3_ADD;
      alu_subsra = 1'b0;
      br_opcode  = BR_NONE;

      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         rs1_zero   = actl.rs1_zero;
         mux2_sel   = actl.mux2;
         mux3_sel   = actl.mux3;
         alu_func3  = actl.func3;
         alu_subsra = actl.subsra;
         br_opcode  = actl.br_opcode;
      end

      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (iclass == C_HALT) begin
               state_d = S_HALT;
            end else if (iclass == C_NOP) begin
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            tmo_d = '0;
            case (iclass)
               C_BRANCH: begin
                  pc_we   = 1'b1;
                  pc_src  = branch_next;
                  state_d = S_FETCH;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end
         // ALU keeps the address add; the DM takes its access width from ir[14:12].
         S_MEM: begin
            dm_req = 1'b1;
            dm_we  = (iclass == C_STORE);
            if (dm_ready) begin
               if (iclass == C_STORE) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
            case (iclass)
               C_LOAD:        mux4_sel = MUX4_DM;
               C_JAL, C_JALR: begin
                  mux4_sel = MUX4_PC4;
                  pc_src   = PC_SRC_ALU;
               end
               default:       mux4_sel = MUX4_ALU;
            endcase
         end
         S_HALT, S_FAULT: ;
         default: state_d = S_FAULT;
      endcase
   end

   assign ir      = ir_q;
   assign instret = instret_q;
   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle expected control vectors
// are queued with their stimulus and compared as the sequencer steps.
`timescale 1ns/1ps
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] im_instr = 32'hFFFF_FFFF;
   logic        branch_next = 1'b0;
   logic        dm_ready = 1'b0;
   logic [31:0] ir, instret;
   logic        rs1_zero, pc_we, pc_src, rf_we, dm_req, dm_we;
   logic [2:0]  alu_func3, state;
   logic        alu_subsra, mux2_sel, mux3_sel, halted, fault;
   logic [1:0]  mux4_sel;
   logic [4:0]  br_opcode;

   mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .im_instr(im_instr), .branch_next(branch_next),
      .dm_ready(dm_ready), .ir(ir), .rs1_zero(rs1_zero), .pc_we(pc_we),
      .pc_src(pc_src), .rf_we(rf_we), .dm_req(dm_req), .dm_we(dm_we),
      .alu_func3(alu_func3), .alu_subsra(alu_subsra), .mux2_sel(mux2_sel),
      .mux3_sel(mux3_sel), .mux4_sel(mux4_sel), .br_opcode(br_opcode),
      .state(state), .halted(halted), .fault(fault), .instret(instret)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3,
                          SW = 3'd4, SH = 3'd5, SX = 3'd6;
   localparam logic [4:0] BN = 5'b11111, BJ = 5'b01111;

   typedef struct packed {
      logic [2:0]  st;
      logic        pc_we, pc_src, rf_we, dm_req, dm_we;
      logic [1:0]  m4;
      logic        m2, m3;
      logic [2:0]  f3;
      logic        sra;
      logic [4:0]  br;
      logic        rz, halted, fault;
      logic [31:0] instret;
   } obs_t;

   typedef struct packed {
      obs_t        o;
      logic [31:0] instr;
      logic        bn, rdy;
   } step_t;

   step_t       sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_instret = 32'd0;
   logic [31:0] cur_instr = 32'd0;

   function automatic obs_t observe();
      return {state, pc_we, pc_src, rf_we, dm_req, dm_we, mux4_sel, mux2_sel,
              mux3_sel, alu_func3, alu_subsra, br_opcode, rs1_zero, halted,
              fault, instret};
   endfunction

   // Queue one expected cycle; the instret model advances on expected pc_we.
   task automatic push(input logic [2:0] st, input logic pcwe, input logic pcsrc,
                       input logic rfwe, input logic req, input logic we,
                       input logic [1:0] m4, input logic m2, input logic m3,
                       input logic [2:0] f3, input logic sra, input logic [4:0] br,
                       input logic rz, input logic bn, input logic rdy);
      step_t s;
      s.o     = {st, pcwe, pcsrc, rfwe, req, we, m4, m2, m3, f3, sra, br, rz,
                 (st == SH), (st == SX), exp_instret};
      s.instr = cur_instr;
      s.bn    = bn;
      s.rdy   = rdy;
      sb.push_back(s);
      if (pcwe) exp_instret = exp_instret + 32'd1;
   endtask

   task automatic push_idle(input logic [2:0] st, input logic bn, input logic rdy);
      push(st, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, BN, 0, bn, rdy);
   endtask

   task automatic push_fd(input logic [31:0] instr, input logic bn, input logic rdy);
      cur_instr = instr;
      push_idle(SF, bn, rdy);
      push_idle(SD, bn, rdy);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (state !== SF || ir !== 32'd0 || instret !== 32'd0) begin
         bad++;
         $display("FAIL reset_regs got st=%0d ir=%h instret=%0d want st=0 ir=0 instret=0", state, ir, instret);
      end
      total++;
      if ({pc_we, rf_we, dm_req, dm_we, halted, fault} !== 6'b0) begin
         bad++;
         $display("FAIL reset_enables got %b want 000000", {pc_we, rf_we, dm_req, dm_we, halted, fault});
      end
      total++;
      if (br_opcode !== BN || {mux2_sel, mux3_sel, mux4_sel, alu_func3, alu_subsra, rs1_zero, pc_src} !== 10'b0) begin
         bad++;
         $display("FAIL reset_muxes got br=%b mux=%b want br=11111 mux=0", br_opcode,
                  {mux2_sel, mux3_sel, mux4_sel, alu_func3, alu_subsra, rs1_zero, pc_src});
      end
      @(negedge clk);
      reset = 1'b0;
      exp_instret = 32'd0;
   endtask

   task automatic test_alu_ops();
      step_t s;
      int    n = 0;
      push_fd(32'h002081B3, 0, 0);      // add x3,x1,x2
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 0, 3'b000, 0, BN, 0, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 0, 3'b000, 0, BN, 0, 0, 0);
      push_fd(32'h40208133, 0, 0);      // sub x2,x1,x2
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 0, 3'b000, 1, BN, 0, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 0, 3'b000, 1, BN, 0, 0, 0);
      push_fd(32'h4030D093, 0, 0);      // srai x1,x1,3
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b101, 1, BN, 0, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 1, 3'b101, 1, BN, 0, 0, 0);
      push_fd(32'hC0000093, 0, 0);      // addi x1,x0,-1024: bit30 set, no sub
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push_fd(32'h123450B7, 0, 0);      // lui x1,0x12345
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 1, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 1, 3'b000, 0, BN, 1, 0, 0);
      push_fd(32'h008000EF, 0, 0);      // jal x1,+8
      push(SE, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 0, BJ, 0, 0, 0);
      push(SW, 1, 1, 1, 0, 0, 2'b10, 0, 1, 3'b000, 0, BJ, 0, 0, 0);
      cur_instr = 32'h0000007F;         // unknown opcode retires as NOP
      push_idle(SF, 0, 0);
      push(SD, 1, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, BN, 0, 0, 0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL alu_ops step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load();
      step_t s;
      int    n = 0;
      push_fd(32'h0000A283, 0, 1);      // lw x5,0(x1); dm_ready outside MEM ignored
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 1);
      for (int i = 0; i < 3; i++)
         push(SM, 0, 0, 0, 1, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SM, 0, 0, 0, 1, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 1);
      push(SW, 1, 0, 1, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push_fd(32'h0000A283, 0, 0);      // zero-wait load right behind it
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SM, 0, 0, 0, 1, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 1);
      push(SW, 1, 0, 1, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL load step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      step_t s;
      int    n = 0;
      push_fd(32'h00208463, 0, 0);      // beq taken
      push(SE, 1, 1, 0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 5'b00000, 0, 1, 0);
      push_fd(32'h00208463, 1, 0);      // beq not taken; branch_next high before EXEC
      push(SE, 1, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 5'b00000, 0, 0, 0);
      push_fd(32'h00209463, 0, 0);      // bne taken
      push(SE, 1, 1, 0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 5'b00001, 0, 1, 0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL branch step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_store_timeout();
      step_t s;
      int    n = 0;
      push_fd(32'h0020A023, 0, 0);      // sw, ready on first MEM cycle
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SM, 1, 0, 0, 1, 1, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 1);
      push_fd(32'h0020A023, 0, 0);      // sw, memory never answers
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         push(SM, 0, 0, 0, 1, 1, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         push_idle(SX, 1, 1);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL store_timeout step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      total++;
      if (fault !== 1'b0 || state !== SF || instret !== 32'd0) begin
         bad++;
         $display("FAIL fault_clear got fault=%b st=%0d instret=%0d want 0 0 0", fault, state, instret);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_instret = 32'd0;
   endtask

   task automatic test_halt();
      step_t s;
      int    n = 0;
      push_fd(32'h0000_0000, 0, 1);
      for (int i = 0; i < 3; i++)
         push_idle(SH, 1, 1);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL halt step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_instret = 32'd0;
   endtask

   task automatic test_reset_mid_mem();
      step_t s;
      int    n = 0;
      push_fd(32'h002081B3, 0, 0);
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 0, 3'b000, 0, BN, 0, 0, 0);
      push(SW, 1, 0, 1, 0, 0, 2'b01, 1, 0, 3'b000, 0, BN, 0, 0, 0);
      push_fd(32'h0020A023, 0, 0);
      push(SE, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SM, 0, 0, 0, 1, 1, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      push(SM, 0, 0, 0, 1, 1, 2'b00, 1, 1, 3'b000, 0, BN, 0, 0, 0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         im_instr = s.instr; branch_next = s.bn; dm_ready = s.rdy;
         #1;
         total++; n++;
         if (observe() !== s.o) begin
            bad++;
            $display("FAIL abort step%0d got=%h want=%h", n, observe(), s.o);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (dm_req !== 1'b1 || state !== SM || instret !== 32'd1) begin
         bad++;
         $display("FAIL abort_pre got req=%b st=%0d instret=%0d want 1 3 1", dm_req, state, instret);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (dm_req !== 1'b0 || dm_we !== 1'b0 || state !== SF || instret !== 32'd0) begin
         bad++;
         $display("FAIL abort_reset got req=%b we=%b st=%0d instret=%0d want 0 0 0 0",
                  dm_req, dm_we, state, instret);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_instret = 32'd0;
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load();
      test_branch();
      test_store_timeout();
      test_halt();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
